// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage: holds one retiring instruction,
// waits for load data, extracts/extends it and drives the register-file write port.
module wb_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  MEM_VALID,
  output logic                  MEM_READY,
  input  logic                  MEM_WEN,
  input  logic [ADDR_WIDTH-1:0] MEM_RD_SEL,
  input  logic [1:0]            MEM_WB_SEL,
  input  logic [2:0]            MEM_FUNCT3,
  input  logic [1:0]            MEM_ADDR_LO,
  input  logic [DATA_WIDTH-1:0] MEM_ALU_RESULT,
  input  logic [DATA_WIDTH-1:0] MEM_PC_PLUS4,
  input  logic                  DMEM_RVALID,
  input  logic [DATA_WIDTH-1:0] DMEM_RDATA,
  output logic                  WB_WEN,
  output logic [ADDR_WIDTH-1:0] WB_RD_SEL,
  output logic [DATA_WIDTH-1:0] WB_DATA,
  output logic                  LOAD_ERR,
  output logic [CNT_WIDTH-1:0]  RETIRE_CNT
);

  typedef enum logic [1:0] {
    S_EMPTY     = 2'b00,
    S_WAIT_LOAD = 2'b01,
    S_FULL      = 2'b10
  } state_t;

  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  state_t                  state_q, state_d;
  logic                    ld_wen_q, ld_wen_d;
  logic [ADDR_WIDTH-1:0]   ld_rd_q, ld_rd_d;
  logic [2:0]              ld_funct3_q, ld_funct3_d;
  logic [1:0]              ld_addr_lo_q, ld_addr_lo_d;
  logic                    wb_wen_q, wb_wen_d;
  logic [ADDR_WIDTH-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0]   wb_data_q, wb_data_d;
  logic                    load_err_q, load_err_d;
  logic [CNT_WIDTH-1:0]    retire_cnt_q, retire_cnt_d;
  logic                    mem_ready_s;
  logic                    transfer_s;
  logic                    fault_s;

  function automatic logic load_fault(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic f;
    case (funct3)
      3'b000, 3'b100: f = 1'b0;
      3'b001, 3'b101: f = addr_lo[0];
      3'b010:         f = (addr_lo != 2'b00);
      default:        f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [2:0] funct3,
                                                         input logic [1:0] addr_lo,
                                                         input logic [DATA_WIDTH-1:0] rdata);
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] r;
    case (addr_lo)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    if (addr_lo[1]) begin
      h = rdata[31:16];
    end else begin
      h = rdata[15:0];
    end
    case (funct3)
      3'b000:  r = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  r = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b010:  r = rdata;
      3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, h};
      default: r = {DATA_WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // The stage only stalls upstream while a load response is outstanding.
  assign mem_ready_s = (state_q != S_WAIT_LOAD);
  assign transfer_s  = MEM_VALID & mem_ready_s;
  assign fault_s     = load_fault(ld_funct3_q, ld_addr_lo_q);

  assign MEM_READY  = mem_ready_s & RESET_N;
  assign WB_WEN     = wb_wen_q;
  assign WB_RD_SEL  = wb_rd_q;
  assign WB_DATA    = wb_data_q;
  assign LOAD_ERR   = load_err_q;
  assign RETIRE_CNT = retire_cnt_q;

  // Next-state and commit-register computation; WB_* are set up on entry to FULL.
  always_comb begin
    state_d      = state_q;
    ld_wen_d     = ld_wen_q;
    ld_rd_d      = ld_rd_q;
    ld_funct3_d  = ld_funct3_q;
    ld_addr_lo_d = ld_addr_lo_q;
    wb_wen_d     = 1'b0;
    load_err_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;

    if (state_q == S_FULL) begin
      retire_cnt_d = retire_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      retire_cnt_d = retire_cnt_q;
    end

    case (state_q)
      S_EMPTY, S_FULL: begin
        if (transfer_s) begin
          if (MEM_WB_SEL == WB_SEL_LOAD) begin
            state_d      = S_WAIT_LOAD;
            ld_wen_d     = MEM_WEN;
            ld_rd_d      = MEM_RD_SEL;
            ld_funct3_d  = MEM_FUNCT3;
            ld_addr_lo_d = MEM_ADDR_LO;
          end else begin
            state_d  = S_FULL;
            wb_wen_d = MEM_WEN & (MEM_RD_SEL != {ADDR_WIDTH{1'b0}});
            wb_rd_d  = MEM_RD_SEL;
            if (MEM_WB_SEL == WB_SEL_PC4) begin
              wb_data_d = MEM_PC_PLUS4;
            end else begin
              wb_data_d = MEM_ALU_RESULT;
            end
          end
        end else begin
          state_d = S_EMPTY;
        end
      end
      S_WAIT_LOAD: begin
        if (DMEM_RVALID) begin
          state_d    = S_FULL;
          wb_wen_d   = ld_wen_q & (ld_rd_q != {ADDR_WIDTH{1'b0}}) & ~fault_s;
          load_err_d = fault_s;
          wb_rd_d    = ld_rd_q;
          if (fault_s) begin
            wb_data_d = {DATA_WIDTH{1'b0}};
          end else begin
            wb_data_d = load_extract(ld_funct3_q, ld_addr_lo_q, DMEM_RDATA);
          end
        end else begin
          state_d = S_WAIT_LOAD;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  // Stage registers; reset discards any held instruction.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_EMPTY;
      ld_wen_q     <= 1'b0;
      ld_rd_q      <= {ADDR_WIDTH{1'b0}};
      ld_funct3_q  <= 3'b000;
      ld_addr_lo_q <= 2'b00;
      wb_wen_q     <= 1'b0;
      wb_rd_q      <= {ADDR_WIDTH{1'b0}};
      wb_data_q    <= {DATA_WIDTH{1'b0}};
      load_err_q   <= 1'b0;
      retire_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      ld_wen_q     <= ld_wen_d;
      ld_rd_q      <= ld_rd_d;
      ld_funct3_q  <= ld_funct3_d;
      ld_addr_lo_q <= ld_addr_lo_d;
      wb_wen_q     <= wb_wen_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      load_err_q   <= load_err_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for single commits plus hand-written
// stall, back-to-back, async-reset and counter-wrap sequences.
module tb_wb_stage;

  logic        CLK;
  logic        RESET_N;
  logic        MEM_VALID;
  logic        MEM_READY;
  logic        MEM_WEN;
  logic [4:0]  MEM_RD_SEL;
  logic [1:0]  MEM_WB_SEL;
  logic [2:0]  MEM_FUNCT3;
  logic [1:0]  MEM_ADDR_LO;
  logic [31:0] MEM_ALU_RESULT;
  logic [31:0] MEM_PC_PLUS4;
  logic        DMEM_RVALID;
  logic [31:0] DMEM_RDATA;
  logic        WB_WEN;
  logic [4:0]  WB_RD_SEL;
  logic [31:0] WB_DATA;
  logic        LOAD_ERR;
  logic [31:0] RETIRE_CNT;

  logic        w_ready, w_wen, w_err;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  logic [1:0]  w_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_cnt;

  wb_stage dut (
    .CLK(CLK), .RESET_N(RESET_N), .MEM_VALID(MEM_VALID), .MEM_READY(MEM_READY),
    .MEM_WEN(MEM_WEN), .MEM_RD_SEL(MEM_RD_SEL), .MEM_WB_SEL(MEM_WB_SEL),
    .MEM_FUNCT3(MEM_FUNCT3), .MEM_ADDR_LO(MEM_ADDR_LO), .MEM_ALU_RESULT(MEM_ALU_RESULT),
    .MEM_PC_PLUS4(MEM_PC_PLUS4), .DMEM_RVALID(DMEM_RVALID), .DMEM_RDATA(DMEM_RDATA),
    .WB_WEN(WB_WEN), .WB_RD_SEL(WB_RD_SEL), .WB_DATA(WB_DATA), .LOAD_ERR(LOAD_ERR),
    .RETIRE_CNT(RETIRE_CNT)
  );

  // Narrow-counter instance on the same stimulus, used to observe wrap-around.
  wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(2)) dut_w (
    .CLK(CLK), .RESET_N(RESET_N), .MEM_VALID(MEM_VALID), .MEM_READY(w_ready),
    .MEM_WEN(MEM_WEN), .MEM_RD_SEL(MEM_RD_SEL), .MEM_WB_SEL(MEM_WB_SEL),
    .MEM_FUNCT3(MEM_FUNCT3), .MEM_ADDR_LO(MEM_ADDR_LO), .MEM_ALU_RESULT(MEM_ALU_RESULT),
    .MEM_PC_PLUS4(MEM_PC_PLUS4), .DMEM_RVALID(DMEM_RVALID), .DMEM_RDATA(DMEM_RDATA),
    .WB_WEN(w_wen), .WB_RD_SEL(w_rd), .WB_DATA(w_data), .LOAD_ERR(w_err),
    .RETIRE_CNT(w_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  sel;
    logic        wen;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    logic        e_wen;
    logic [31:0] e_data;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] sel, logic wen, logic [4:0] rd, logic [2:0] f3,
                              logic [1:0] lo, logic [31:0] alu, logic [31:0] pc4,
                              logic [31:0] rdata, logic e_wen, logic [31:0] e_data,
                              logic e_err);
    vec_t v;
    v.sel = sel; v.wen = wen; v.rd = rd; v.f3 = f3; v.lo = lo; v.alu = alu; v.pc4 = pc4;
    v.rdata = rdata; v.e_wen = e_wen; v.e_data = e_data; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name);
    chk({name, "_cnt"}, RETIRE_CNT, exp_cnt);
    chk({name, "_cnt2"}, {30'd0, w_cnt}, exp_cnt & 32'd3);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic wen, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu,
                       input logic [31:0] pc4);
    MEM_WB_SEL = sel; MEM_WEN = wen; MEM_RD_SEL = rd; MEM_FUNCT3 = f3;
    MEM_ADDR_LO = lo; MEM_ALU_RESULT = alu; MEM_PC_PLUS4 = pc4;
  endtask

  initial begin
    RESET_N = 1'b1; MEM_VALID = 1'b0; DMEM_RVALID = 1'b0; DMEM_RDATA = 32'h0;
    drive(2'b00, 1'b0, 5'd0, 3'b000, 2'b00, 32'h0, 32'h0);
    exp_cnt = 32'd0;

    vecs.push_back(mk(2'b00, 1'b1, 5'd5,  3'b000, 2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0, 1'b1, 32'h1234_5678, 1'b0));
    vecs.push_back(mk(2'b11, 1'b1, 5'd9,  3'b000, 2'b00, 32'hDEAD_BEEF, 32'h0000_0020, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(2'b10, 1'b1, 5'd1,  3'b000, 2'b00, 32'h0000_FFFF, 32'h0000_0104, 32'h0, 1'b1, 32'h0000_0104, 1'b0));
    vecs.push_back(mk(2'b00, 1'b0, 5'd4,  3'b000, 2'b00, 32'h0000_0055, 32'h0000_0008, 32'h0, 1'b0, 32'h0000_0055, 1'b0));
    vecs.push_back(mk(2'b10, 1'b1, 5'd0,  3'b000, 2'b00, 32'h0000_0001, 32'h0000_0008, 32'h0, 1'b0, 32'h0000_0008, 1'b0));
    vecs.push_back(mk(2'b00, 1'b1, 5'd8,  3'b011, 2'b01, 32'h0000_0AAA, 32'h0, 32'h0, 1'b1, 32'h0000_0AAA, 1'b0));
    vecs.push_back(mk(2'b01, 1'b1, 5'd7,  3'b000, 2'b11, 32'h0, 32'h0, 32'h80FF_0011, 1'b1, 32'hFFFF_FF80, 1'b0));
    vecs.push_back(mk(2'b01, 1'b1, 5'd7,  3'b000, 2'b00, 32'h0, 32'h0, 32'h80FF_0011, 1'b1, 32'h0000_0011, 1'b0));
    vecs.push_back(mk(2'b01, 1'b1, 5'd7,  3'b100, 2'b10, 32'h0, 32'h0, 32'h80FF_0011, 1'b1, 32'h0000_00FF, 1'b0));
    vecs.push_back(mk(2'b01, 1'b1, 5'd7,  3'b000, 2'b10, 32'h0, 32'h0, 32'h80FF_0011, 1'b1, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(2'b01, 1'b1, 5'd3,  3'b001, 2'b10, 32'h0, 32'h0, 32'hBEEF_0000, 1'b1, 32'hFFFF_BEEF, 1'b0));
    vecs.push_back(mk(2'b01, 1'b1, 5'd3,  3'b101, 2'b10, 32'h0, 32'h0, 32'hBEEF_0000, 1'b1, 32'h0000_BEEF, 1'b0));
    vecs.push_back(mk(2'b01, 1'b1, 5'd3,  3'b001, 2'b00, 32'h0, 32'h0, 32'h1234_8765, 1'b1, 32'hFFFF_8765, 1'b0));
    vecs.push_back(mk(2'b01, 1'b1, 5'd3,  3'b101, 2'b00, 32'h0, 32'h0, 32'h1234_8765, 1'b1, 32'h0000_8765, 1'b0));
    vecs.push_back(mk(2'b01, 1'b1, 5'd2,  3'b010, 2'b00, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0));
    vecs.push_back(mk(2'b01, 1'b1, 5'd6,  3'b100, 2'b01, 32'h0, 32'h0, 32'h0000_AB00, 1'b1, 32'h0000_00AB, 1'b0));
    vecs.push_back(mk(2'b01, 1'b1, 5'd6,  3'b000, 2'b01, 32'h0, 32'h0, 32'h0000_AB00, 1'b1, 32'hFFFF_FFAB, 1'b0));
    vecs.push_back(mk(2'b01, 1'b1, 5'd0,  3'b010, 2'b00, 32'h0, 32'h0, 32'h1111_2222, 1'b0, 32'h1111_2222, 1'b0));
    vecs.push_back(mk(2'b01, 1'b1, 5'd2,  3'b010, 2'b01, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(2'b01, 1'b1, 5'd2,  3'b001, 2'b01, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(2'b01, 1'b1, 5'd2,  3'b101, 2'b11, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(2'b01, 1'b1, 5'd2,  3'b011, 2'b00, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(2'b01, 1'b1, 5'd2,  3'b110, 2'b00, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(2'b01, 1'b1, 5'd2,  3'b111, 2'b00, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b1));

    // Reset state, with a real falling edge on RESET_N.
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_ready", {31'd0, MEM_READY}, 32'd0);
    chk("rst_wen", {31'd0, WB_WEN}, 32'd0);
    chk("rst_rd", {27'd0, WB_RD_SEL}, 32'd0);
    chk("rst_data", WB_DATA, 32'd0);
    chk("rst_err", {31'd0, LOAD_ERR}, 32'd0);
    chk_cnt("rst");
    tick(); tick();
    RESET_N = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, MEM_READY}, 32'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].wen, vecs[i].rd, vecs[i].f3, vecs[i].lo, vecs[i].alu, vecs[i].pc4);
      MEM_VALID = 1'b1;
      DMEM_RVALID = 1'b1;
      DMEM_RDATA = 32'h5A5A_5A5A;
      tick();
      MEM_VALID = 1'b0;
      DMEM_RVALID = 1'b0;
      if (vecs[i].sel == 2'b01) begin
        chk("vec_wait_ready", {31'd0, MEM_READY}, 32'd0);
        chk("vec_wait_wen", {31'd0, WB_WEN}, 32'd0);
        DMEM_RVALID = 1'b1;
        DMEM_RDATA = vecs[i].rdata;
        tick();
        DMEM_RVALID = 1'b0;
        DMEM_RDATA = 32'h0;
      end
      chk("vec_wen", {31'd0, WB_WEN}, {31'd0, vecs[i].e_wen});
      chk("vec_rd", {27'd0, WB_RD_SEL}, {27'd0, vecs[i].rd});
      chk("vec_data", WB_DATA, vecs[i].e_data);
      chk("vec_err", {31'd0, LOAD_ERR}, {31'd0, vecs[i].e_err});
      chk_cnt("vec_commit");
      tick();
      exp_cnt = exp_cnt + 32'd1;
      chk_cnt("vec_after");
      chk("vec_after_wen", {31'd0, WB_WEN}, 32'd0);
      chk("vec_after_err", {31'd0, LOAD_ERR}, 32'd0);
      chk("vec_after_data_hold", WB_DATA, vecs[i].e_data);
    end

    // Load stalled three cycles while the next instruction is held upstream.
    drive(2'b01, 1'b1, 5'd7, 3'b000, 2'b11, 32'h0, 32'h0);
    MEM_VALID = 1'b1;
    tick();
    drive(2'b00, 1'b1, 5'd10, 3'b000, 2'b00, 32'h0000_000A, 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("stall_ready", {31'd0, MEM_READY}, 32'd0);
      chk("stall_wen", {31'd0, WB_WEN}, 32'd0);
      tick();
    end
    DMEM_RVALID = 1'b1;
    DMEM_RDATA = 32'h80FF_0011;
    tick();
    DMEM_RVALID = 1'b0;
    chk("stall_ld_wen", {31'd0, WB_WEN}, 32'd1);
    chk("stall_ld_rd", {27'd0, WB_RD_SEL}, 32'd7);
    chk("stall_ld_data", WB_DATA, 32'hFFFF_FF80);
    chk("stall_ld_ready", {31'd0, MEM_READY}, 32'd1);
    chk_cnt("stall_ld");
    tick();
    exp_cnt = exp_cnt + 32'd1;
    chk("stall_alu_wen", {31'd0, WB_WEN}, 32'd1);
    chk("stall_alu_rd", {27'd0, WB_RD_SEL}, 32'd10);
    chk("stall_alu_data", WB_DATA, 32'h0000_000A);
    chk_cnt("stall_alu");
    MEM_VALID = 1'b0;
    tick();
    exp_cnt = exp_cnt + 32'd1;
    chk("stall_end_wen", {31'd0, WB_WEN}, 32'd0);
    chk_cnt("stall_end");

    // Back-to-back ALU commits, then an rd=0 link op.
    MEM_VALID = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      drive(2'b00, 1'b1, r[4:0], 3'b000, 2'b00, 32'h0000_0111 * r, 32'h0);
      tick();
      chk("b2b_wen", {31'd0, WB_WEN}, 32'd1);
      chk("b2b_rd", {27'd0, WB_RD_SEL}, r);
      chk("b2b_data", WB_DATA, 32'h0000_0111 * r);
      chk_cnt("b2b");
      exp_cnt = exp_cnt + 32'd1;
    end
    drive(2'b10, 1'b1, 5'd0, 3'b000, 2'b00, 32'h0000_0999, 32'h0000_0444);
    tick();
    chk("rd0_wen", {31'd0, WB_WEN}, 32'd0);
    chk("rd0_data", WB_DATA, 32'h0000_0444);
    chk_cnt("rd0");
    exp_cnt = exp_cnt + 32'd1;
    MEM_VALID = 1'b0;
    tick();
    chk_cnt("rd0_after");

    // Commit cycle accepting a load: outputs hold while it waits.
    MEM_VALID = 1'b1;
    drive(2'b00, 1'b1, 5'd11, 3'b000, 2'b00, 32'h0000_0077, 32'h0);
    tick();
    chk("acc_alu_wen", {31'd0, WB_WEN}, 32'd1);
    drive(2'b01, 1'b1, 5'd12, 3'b100, 2'b01, 32'h0, 32'h0);
    tick();
    exp_cnt = exp_cnt + 32'd1;
    MEM_VALID = 1'b0;
    chk("acc_wait_wen", {31'd0, WB_WEN}, 32'd0);
    chk("acc_wait_ready", {31'd0, MEM_READY}, 32'd0);
    chk("acc_wait_rd_hold", {27'd0, WB_RD_SEL}, 32'd11);
    chk("acc_wait_data_hold", WB_DATA, 32'h0000_0077);
    chk_cnt("acc_wait");
    DMEM_RVALID = 1'b1;
    DMEM_RDATA = 32'h0000_AB00;
    tick();
    DMEM_RVALID = 1'b0;
    chk("acc_ld_wen", {31'd0, WB_WEN}, 32'd1);
    chk("acc_ld_rd", {27'd0, WB_RD_SEL}, 32'd12);
    chk("acc_ld_data", WB_DATA, 32'h0000_00AB);
    tick();
    exp_cnt = exp_cnt + 32'd1;
    chk_cnt("acc_end");

    // Asynchronous reset in WAIT_LOAD, then a stale response after release.
    MEM_VALID = 1'b1;
    drive(2'b01, 1'b1, 5'd6, 3'b010, 2'b00, 32'h0, 32'h0);
    tick();
    MEM_VALID = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    exp_cnt = 32'd0;
    chk("arst_ready", {31'd0, MEM_READY}, 32'd0);
    chk("arst_data", WB_DATA, 32'd0);
    chk("arst_rd", {27'd0, WB_RD_SEL}, 32'd0);
    chk_cnt("arst");
    tick();
    RESET_N = 1'b1;
    DMEM_RVALID = 1'b1;
    DMEM_RDATA = 32'h1357_9BDF;
    tick();
    chk("stale_wen", {31'd0, WB_WEN}, 32'd0);
    chk("stale_data", WB_DATA, 32'd0);
    chk("stale_ready", {31'd0, MEM_READY}, 32'd1);
    tick();
    DMEM_RVALID = 1'b0;
    chk("stale_wen2", {31'd0, WB_WEN}, 32'd0);
    chk_cnt("stale");

    // Counter wrap on the two-bit instance.
    MEM_VALID = 1'b1;
    drive(2'b00, 1'b1, 5'd13, 3'b000, 2'b00, 32'h0000_0001, 32'h0);
    tick(); tick(); tick();
    MEM_VALID = 1'b0;
    tick();
    exp_cnt = 32'd3;
    chk_cnt("wrap_pre");
    MEM_VALID = 1'b1;
    tick();
    MEM_VALID = 1'b0;
    tick();
    exp_cnt = 32'd4;
    chk_cnt("wrap_post");
    chk("wrap_zero", {30'd0, w_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
